// File: rtl/led_4_flash_seq.sv
// Four-LED light show: forward chase, reverse chase, blink, looping forever.
// A free-running divider advances a 12-step pattern index once every TICK_CYCLES clocks.
module led_4_flash_seq #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3
);

  localparam int              CW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]      STEP_LAST = 4'd11;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    step;
  logic [3:0]    pattern;

  assign tick = (cnt == CNT_MAX);

  // rst_n is active-high: the board reset net is named this way but asserts at 1
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Out-of-range steps fall back to 0 on the next tick
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     step <= 4'd0;
    else if (tick) step <= (step >= STEP_LAST) ? 4'd0 : step + 4'd1;
  end

  always_comb begin
    pattern = 4'b0000;
    case (step)
      4'd0:    pattern = 4'b0001;
      4'd1:    pattern = 4'b0010;
      4'd2:    pattern = 4'b0100;
      4'd3:    pattern = 4'b1000;
      4'd4:    pattern = 4'b1000;
      4'd5:    pattern = 4'b0100;
      4'd6:    pattern = 4'b0010;
      4'd7:    pattern = 4'b0001;
      4'd8:    pattern = 4'b1111;
      4'd9:    pattern = 4'b0000;
      4'd10:   pattern = 4'b1111;
      4'd11:   pattern = 4'b0000;
      default: pattern = 4'b0000;
    endcase
  end

  // Registered outputs keep the pins glitch-free; they trail step by one clock
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) {led3, led2, led1, led0} <= 4'b0000;
    else       {led3, led2, led1, led0} <= pattern;
  end

endmodule

// File: tb/tb_led_4_flash_seq.sv
// Bench for led_4_flash_seq: a TICK_CYCLES=4 and a TICK_CYCLES=2 instance share clock and reset.
// Expected patterns are queued when each cycle is driven and popped after the clock edge.
module tb_led_4_flash_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a0, a1, a2, a3;
  logic b0, b1, b2, b3;

  led_4_flash_seq #(.TICK_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .led0(a0), .led1(a1), .led2(a2), .led3(a3));
  led_4_flash_seq #(.TICK_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .led0(b0), .led1(b1), .led2(b2), .led3(b3));

  always #10 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] e4;
    logic [3:0] e2;
  } vec_t;

  localparam int NRST = 10;
  localparam int NRUN = 49;
  localparam int NVEC = NRST + NRUN;

  logic [3:0] pat [12];
  vec_t       vecs [NVEC];
  vec_t       sb [$];
  int         checks = 0;
  int         errors = 0;

  wire [3:0] led4 = {a3, a2, a1, a0};
  wire [3:0] led2w = {b3, b2, b1, b0};

  function automatic logic [3:0] exp_at(input int n, input int t);
    return pat[((n - 1) / t) % 12];
  endfunction

  task automatic chk(input string name, input int n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, compare after the next rising edge
  task automatic run_cycle(input string name, input int n, input vec_t v);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({name, "_t4"}, n, led4, e.e4);
    chk({name, "_t2"}, n, led2w, e.e2);
  endtask

  task automatic free_run(input string name, input int n0, input int cnt);
    vec_t v;
    for (int n = n0; n < n0 + cnt; n++) begin
      v.rst = 1'b0;
      v.e4  = exp_at(n, 4);
      v.e2  = exp_at(n, 2);
      run_cycle(name, n, v);
    end
  endtask

  initial begin
    vec_t v;
    pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2]  = 4'b0100; pat[3]  = 4'b1000;
    pat[4] = 4'b1000; pat[5] = 4'b0100; pat[6]  = 4'b0010; pat[7]  = 4'b0001;
    pat[8] = 4'b1111; pat[9] = 4'b0000; pat[10] = 4'b1111; pat[11] = 4'b0000;

    for (int i = 0; i < NVEC; i++) begin
      if (i < NRST) begin
        vecs[i].rst = 1'b1;
        vecs[i].e4  = 4'b0000;
        vecs[i].e2  = 4'b0000;
      end else begin
        vecs[i].rst = 1'b0;
        vecs[i].e4  = exp_at(i - NRST + 1, 4);
        vecs[i].e2  = exp_at(i - NRST + 1, 2);
      end
    end

    // Reset acts before any clock edge
    #1;
    chk("async_reset_t4", 0, led4, 4'b0000);
    chk("async_reset_t2", 0, led2w, 4'b0000);

    // Reset hold, release, one full loop and the wrap back to step 0
    for (int i = 0; i < NVEC; i++)
      run_cycle(i < NRST ? "reset_hold" : "free_run", (i < NRST) ? 0 : i - NRST + 1, vecs[i]);

    // Continue into pattern 0100 of the second loop (edge 57 for the 4-cycle instance)
    free_run("second_loop", NRUN + 1, 8);

    // Asynchronous reset between clock edges
    #5;
    rst_n = 1'b1;
    #1;
    chk("mid_reset_t4", 57, led4, 4'b0000);
    chk("mid_reset_t2", 57, led2w, 4'b0000);
    v.rst = 1'b1; v.e4 = 4'b0000; v.e2 = 4'b0000;
    for (int k = 0; k < 3; k++) run_cycle("mid_reset_hold", 0, v);

    // Restart from step 0 with no partial-step carryover
    free_run("restart", 1, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_4_flash_seq.md
Name: led_4_flash_seq

Overview:
- Four-LED pattern sequencer driven by a free-running tick divider.
- Steps through a fixed 12-step light show: forward chase, reverse chase, then all-LED blink. It loops forever.
- Sits at board top level, directly driving four active-high LED pins.
- The default timing targets a 50 MHz clock (20 ns period) with 0.5 s per step.

Parameters:
- TICK_CYCLES, 25_000_000, clock cycles per pattern step. Legal range is 2 or more. Benches override it to a small value, e.g. 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous reset, active-HIGH despite the _n suffix. Asserted when 1; clears all state immediately, with no clock edge needed.
- led0  output  1  LED 0, active-high, registered.
- led1  output  1  LED 1, active-high, registered.
- led2  output  1  LED 2, active-high, registered.
- led3  output  1  LED 3, active-high, registered.

Behaviour:
- Reset (rst_n=1): cnt=0, step=0, led0..led3=0. Takes effect asynchronously and holds while rst_n stays high.
- Divider cnt:
  - Width is ceil(log2(TICK_CYCLES)).
  - Increments every clock.
  - When cnt==TICK_CYCLES-1: cnt goes to 0 and tick=1 for that cycle. Otherwise tick=0.
- Step register step:
  - 4 bits, range 0..11.
  - On tick: step goes to step+1. When step==11 it wraps to 0.
  - No other way to change step.
- Pattern decode, written as {led3,led2,led1,led0}:
  - Steps 0-3 (forward chase): 0001, 0010, 0100, 1000.
  - Steps 4-7 (reverse chase): 1000, 0100, 0010, 0001.
  - Steps 8-11 (blink): 1111, 0000, 1111, 0000.
- Output register:
  - Each clock, {led3..led0} takes decode(step).
  - Outputs therefore lag step by exactly 1 clock.
- Timing after reset release:
  - First rising edge: led0=1, the step-0 pattern.
  - Step 1 pattern appears at edge TICK_CYCLES+1.
  - Step k pattern appears at edge k*TICK_CYCLES+1.
  - Full loop period is 12*TICK_CYCLES clocks.
- Reset mid-operation: outputs drop to 0000 immediately. After release the sequence restarts from step 0 with cnt=0. No partial-step carryover.
- Illegal step values 12-15 are unreachable. If one occurs, decode gives 0000 and the next tick sends step to 0.
- Outputs are glitch-free, since all four are flops.
- Exactly one LED is lit in chase steps.
- No inputs other than clk and rst_n.

Test Plan (TICK_CYCLES=4, clk period 20 ns):
- Hold rst_n=1 for 10 cycles -> led3..led0=0000 throughout. Release rst_n -> 0001 after the first rising edge.
- Free-run 48 cycles from release -> patterns 0001,0010,0100,1000,1000,0100,0010,0001,1111,0000,1111,0000, each held 4 clocks. Then 0001 again at cycle 49.
- Forward-to-reverse boundary: cycles 13-16 show 1000, and cycles 17-20 also show 1000. The repeated 1000 is held 8 clocks contiguous with no glitch.
- Assert rst_n asynchronously mid-step (during pattern 0100, between clock edges) -> outputs 0000 immediately. After release, 0001 is held for a full 4 clocks.
- TICK_CYCLES=2 override -> each pattern held 2 clocks; loop period 24 clocks; wrap 0000 -> 0001 is correct.
- Default TICK_CYCLES=25_000_000 -> the first step change from 0001 to 0010 occurs at 0.5 s (25,000,001 edges after release). Spot-check only.
